act_array_pipe: RTL and testbench

//  NUM_CH-lane activation stage between accumulator array and pooling. Each lane takes signed IN_WIDTH

---
 rtl/act_array_pipe_if.sv | 36 +++
 rtl/act_array_pipe.sv | 171 +++++++++++++++++
 tb/tb_act_array_pipe.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/act_array_pipe_if.sv
// Handshake and configuration bundle between the accumulator array, the
// activation stage and the pooling stage. One bit/element per lane.
interface act_array_pipe_if #(
    parameter int NUM_CH    = 16,
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 8,
    parameter int SHIFT_W   = 4
);
    logic [1:0]                       cfg_mode;
    logic [SHIFT_W-1:0]               cfg_shift;
    logic [OUT_WIDTH-2:0]             cfg_clip;

    logic [NUM_CH-1:0]                acc_valid;
    logic [NUM_CH-1:0]                acc_last;
    logic [NUM_CH-1:0][IN_WIDTH-1:0]  acc_result;
    logic [NUM_CH-1:0]                acc_ready;

    logic [NUM_CH-1:0]                act_valid;
    logic [NUM_CH-1:0]                act_last;
    logic [NUM_CH-1:0][OUT_WIDTH-1:0] act_result;
    logic [NUM_CH-1:0]                pool_ready;

    logic [NUM_CH-1:0]                busy;

    modport master (
        output cfg_mode, cfg_shift, cfg_clip,
        output acc_valid, acc_last, acc_result, pool_ready,
        input  acc_ready, act_valid, act_last, act_result, busy
    );

    modport slave (
        input  cfg_mode, cfg_shift, cfg_clip,
        input  acc_valid, acc_last, acc_result, pool_ready,
        output acc_ready, act_valid, act_last, act_result, busy
    );
endinterface

// File: rtl/act_array_pipe.sv
// NUM_CH independent requantize + activation lanes, two register stages each,
// valid/ready on both sides and per-packet configuration capture.
module act_array_pipe #(
    parameter int NUM_CH    = 16,
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 8,
    parameter int SHIFT_W   = 4
) (
    input logic             clk,
    input logic             rst,
    act_array_pipe_if.slave bus
);

    typedef enum logic {
        IDLE,
        PKT
    } state_t;

    typedef enum logic [1:0] {
        MODE_BYPASS,
        MODE_RELU,
        MODE_CLIP,
        MODE_LEAKY
    } act_mode_t;

    localparam logic signed [IN_WIDTH-1:0] SAT_MAX = IN_WIDTH'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [IN_WIDTH-1:0] SAT_MIN = IN_WIDTH'(-(2 ** (OUT_WIDTH - 1)));

    // Activation followed by saturation to the signed output range.
    function automatic logic [OUT_WIDTH-1:0] activate(
        input logic signed [IN_WIDTH-1:0] y,
        input act_mode_t                  mode,
        input logic [OUT_WIDTH-2:0]       clip
    );
        logic signed [IN_WIDTH-1:0] a;
        logic signed [IN_WIDTH-1:0] clip_ext;
        clip_ext = $signed({{(IN_WIDTH - OUT_WIDTH + 1){1'b0}}, clip});
        unique case (mode)
            MODE_BYPASS: a = y;
            MODE_RELU:   a = y[IN_WIDTH-1] ? '0 : y;
            MODE_CLIP:   a = y[IN_WIDTH-1] ? '0 : ((y > clip_ext) ? clip_ext : y);
            default:     a = y[IN_WIDTH-1] ? (y >>> 3) : y;
        endcase
        if (a > SAT_MAX) begin
            a = SAT_MAX;
        end else if (a < SAT_MIN) begin
            a = SAT_MIN;
        end
        return a[OUT_WIDTH-1:0];
    endfunction

    for (genvar l = 0; l < NUM_CH; l++) begin : g_lane
        state_t                      state_q;
        state_t                      state_d;

        act_mode_t                   mode_q;
        logic [SHIFT_W-1:0]          shift_q;
        logic [OUT_WIDTH-2:0]        clip_q;

        logic                        s1_v;
        logic                        s1_last;
        logic signed [IN_WIDTH-1:0]  s1_data;
        act_mode_t                   s1_mode;
        logic [OUT_WIDTH-2:0]        s1_clip;

        logic                        s2_v;
        logic                        s2_last;
        logic [OUT_WIDTH-1:0]        s2_data;

        logic                        s2_free;
        logic                        s1_load;
        logic                        ready;
        logic                        accept;
        logic signed [IN_WIDTH-1:0]  x;

        logic                        cfg_load;
        act_mode_t                   beat_mode;
        logic [SHIFT_W-1:0]          beat_shift;
        logic [OUT_WIDTH-2:0]        beat_clip;
        logic                        lane_busy;

        // S2 can take a beat when empty or when its beat leaves this cycle.
        assign s2_free = !s2_v || bus.pool_ready[l];
        assign s1_load = !s1_v || s2_free;
        assign ready   = rst && s1_load;
        assign accept  = bus.acc_valid[l] && ready;
        assign x       = bus.acc_result[l];

        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of process evaluation order.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q <= IDLE;
            end else begin
                state_q <= state_d;
            end
        end

        // NOTE: each combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        always_comb begin
            state_d = state_q;
            if (accept) begin
                state_d = bus.acc_last[l] ? IDLE : PKT;
            end
        end

        // In IDLE the live configuration applies to the opening beat.
        always_comb begin
            cfg_load   = accept && (state_q == IDLE);
            beat_mode  = mode_q;
            beat_shift = shift_q;
            beat_clip  = clip_q;
            if (state_q == IDLE) begin
                beat_mode  = act_mode_t'(bus.cfg_mode);
                beat_shift = bus.cfg_shift;
                beat_clip  = bus.cfg_clip;
            end
            lane_busy = (state_q == PKT) || s1_v || s2_v;
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                mode_q  <= MODE_BYPASS;
                shift_q <= '0;
                clip_q  <= '0;
            end else if (cfg_load) begin
                mode_q  <= act_mode_t'(bus.cfg_mode);
                shift_q <= bus.cfg_shift;
                clip_q  <= bus.cfg_clip;
            end
        end

        // Mode and clip ride with the beat so a new packet can start while
        // the previous packet's tail is still in S1.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                s1_v    <= 1'b0;
                s1_last <= 1'b0;
                s1_data <= '0;
                s1_mode <= MODE_BYPASS;
                s1_clip <= '0;
            end else if (s1_load) begin
                s1_v    <= accept;
                s1_last <= bus.acc_last[l];
                s1_data <= x >>> beat_shift;
                s1_mode <= beat_mode;
                s1_clip <= beat_clip;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                s2_v    <= 1'b0;
                s2_last <= 1'b0;
                s2_data <= '0;
            end else if (s2_free) begin
                s2_v    <= s1_v;
                s2_last <= s1_last;
                s2_data <= activate(s1_data, s1_mode, s1_clip);
            end
        end

        assign bus.acc_ready[l]  = ready;
        assign bus.act_valid[l]  = s2_v;
        assign bus.act_last[l]   = s2_last;
        assign bus.act_result[l] = s2_data;
        assign bus.busy[l]       = lane_busy;
    end

endmodule

// File: tb/tb_act_array_pipe.sv
// Randomized bench for act_array_pipe against a per-lane packet/queue model,
// plus a short table of hand-computed vectors.
module tb_act_array_pipe;

    localparam int NUM_CH    = 16;
    localparam int IN_WIDTH  = 16;
    localparam int OUT_WIDTH = 8;
    localparam int SHIFT_W   = 4;
    localparam int OUT_MAX   = (2 ** (OUT_WIDTH - 1)) - 1;
    localparam int OUT_MIN   = -(2 ** (OUT_WIDTH - 1));

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    act_array_pipe_if #(
        .NUM_CH(NUM_CH), .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .SHIFT_W(SHIFT_W)
    ) bus ();

    act_array_pipe #(
        .NUM_CH(NUM_CH), .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .SHIFT_W(SHIFT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        int data;
        bit last;
        int cyc;
    } beat_t;

    beat_t q[NUM_CH][$];
    bit    in_pkt[NUM_CH];
    int    lat_mode[NUM_CH];
    int    lat_shift[NUM_CH];
    int    lat_clip[NUM_CH];
    bit    pend[NUM_CH];
    bit    hold_v[NUM_CH];
    int    hold_d[NUM_CH];
    bit    hold_l[NUM_CH];
    int    fr_start[NUM_CH];
    int    cyc = 0;

    // Reference activation: floor shift, activation rule, clamp.
    function automatic int ref_act(input int x, input int mode, input int shift, input int clip);
        int y;
        int a;
        y = x >>> shift;
        case (mode)
            0:       a = y;
            1:       a = (y < 0) ? 0 : y;
            2:       a = (y < 0) ? 0 : ((y > clip) ? clip : y);
            default: a = (y < 0) ? (y >>> 3) : y;
        endcase
        if (a > OUT_MAX) a = OUT_MAX;
        if (a < OUT_MIN) a = OUT_MIN;
        return a;
    endfunction

    task automatic model_clear();
        for (int l = 0; l < NUM_CH; l++) begin
            q[l].delete();
            in_pkt[l]   = 1'b0;
            pend[l]     = 1'b0;
            hold_v[l]   = 1'b0;
            fr_start[l] = cyc + 1;
        end
    endtask

    // One beat on lane ln with pool_ready high; result checked two cycles later.
    task automatic dir_beat(input int ln, input int mode, input int shift, input int clip,
                            input int x, input bit last, input int exp, input string tag);
        @(negedge clk);
        bus.cfg_mode       = 2'(mode);
        bus.cfg_shift      = SHIFT_W'(shift);
        bus.cfg_clip       = (OUT_WIDTH - 1)'(clip);
        bus.acc_valid[ln]  = 1'b1;
        bus.acc_last[ln]   = last;
        bus.acc_result[ln] = IN_WIDTH'(x);
        #1 check({tag, "_ready"}, bus.acc_ready[ln], 1);
        @(negedge clk);
        bus.acc_valid[ln] = 1'b0;
        #1 check({tag, "_early"}, bus.act_valid[ln], 0);
        @(negedge clk);
        check({tag, "_valid"}, bus.act_valid[ln], 1);
        check({tag, "_data"}, $signed(bus.act_result[ln]), exp);
        check({tag, "_last"}, bus.act_last[ln], last);
    endtask

    // Random traffic. indep: lane 0 stalled downstream, last lane streaming at full rate.
    task automatic run_random(input int ncyc, input int pr_pct, input int v_pct, input bit indep);
        for (int n = 0; n < ncyc; n++) begin
            @(negedge clk);
            cyc++;
            for (int l = 0; l < NUM_CH; l++) begin
                check($sformatf("busy_l%0d", l), bus.busy[l], (in_pkt[l] || q[l].size() > 0));
                if (hold_v[l]) begin
                    check($sformatf("hold_v_l%0d", l), bus.act_valid[l], 1);
                    check($sformatf("hold_d_l%0d", l), $signed(bus.act_result[l]), hold_d[l]);
                    check($sformatf("hold_last_l%0d", l), bus.act_last[l], hold_l[l]);
                end
            end

            if ($urandom_range(0, 3) == 0) begin
                bus.cfg_mode  = 2'($urandom_range(0, 3));
                bus.cfg_shift = SHIFT_W'($urandom_range(0, 15));
                bus.cfg_clip  = (OUT_WIDTH - 1)'($urandom_range(0, OUT_MAX));
            end
            for (int l = 0; l < NUM_CH; l++) begin
                if (!pend[l]) begin
                    bus.acc_valid[l] = ($urandom_range(0, 99) < v_pct);
                    bus.acc_last[l]  = ($urandom_range(0, 3) == 0);
                    if ($urandom_range(0, 1) == 0)
                        bus.acc_result[l] = IN_WIDTH'($urandom_range(0, 800) - 400);
                    else
                        bus.acc_result[l] = IN_WIDTH'($urandom());
                end
                bus.pool_ready[l] = ($urandom_range(0, 99) < pr_pct);
                if (indep && l == 0) bus.pool_ready[l] = 1'b0;
                if (indep && l == NUM_CH - 1) begin
                    bus.pool_ready[l] = 1'b1;
                    bus.acc_valid[l]  = 1'b1;
                end
                if (!bus.pool_ready[l]) fr_start[l] = cyc + 1;
            end

            #1;
            for (int l = 0; l < NUM_CH; l++) begin
                bit acc;
                check($sformatf("ready_l%0d", l), bus.acc_ready[l],
                      (q[l].size() < 2) || bus.pool_ready[l]);
                acc     = bus.acc_valid[l] && bus.acc_ready[l];
                pend[l] = bus.acc_valid[l] && !bus.acc_ready[l];
                if (bus.act_valid[l] && bus.pool_ready[l]) begin
                    if (q[l].size() == 0) begin
                        check($sformatf("spurious_l%0d", l), bus.act_valid[l], 0);
                    end else begin
                        beat_t b;
                        b = q[l].pop_front();
                        check($sformatf("data_l%0d", l), $signed(bus.act_result[l]), b.data);
                        check($sformatf("last_l%0d", l), bus.act_last[l], b.last);
                        if (fr_start[l] <= b.cyc)
                            check($sformatf("latency_l%0d", l), cyc - b.cyc, 2);
                    end
                end
                hold_v[l] = bus.act_valid[l] && !bus.pool_ready[l];
                hold_d[l] = $signed(bus.act_result[l]);
                hold_l[l] = bus.act_last[l];
                if (acc) begin
                    beat_t b;
                    int    xi;
                    xi = $signed(bus.acc_result[l]);
                    if (!in_pkt[l]) begin
                        lat_mode[l]  = int'(bus.cfg_mode);
                        lat_shift[l] = int'(bus.cfg_shift);
                        lat_clip[l]  = int'(bus.cfg_clip);
                    end
                    in_pkt[l] = !bus.acc_last[l];
                    b.data = ref_act(xi, lat_mode[l], lat_shift[l], lat_clip[l]);
                    b.last = bus.acc_last[l];
                    b.cyc  = cyc;
                    q[l].push_back(b);
                end
            end
        end
    endtask

    task automatic mid_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_act_valid", bus.act_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_acc_ready", bus.acc_ready, 0);
        bus.acc_valid = '0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        bus.cfg_mode   = '0;
        bus.cfg_shift  = '0;
        bus.cfg_clip   = '0;
        bus.acc_valid  = '0;
        bus.acc_last   = '0;
        bus.acc_result = '0;
        bus.pool_ready = '0;
        model_clear();

        repeat (2) @(negedge clk);
        #1;
        check("reset_acc_ready", bus.acc_ready, 0);
        check("reset_act_valid", bus.act_valid, 0);
        check("reset_act_last", bus.act_last, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_act_result", bus.act_result, 0);
        @(negedge clk);
        rst = 1'b1;
        bus.pool_ready = '1;

        dir_beat(0, 1, 0, 0, 5, 1'b0, 5, "relu_a");
        dir_beat(0, 1, 0, 0, -7, 1'b0, 0, "relu_b");
        dir_beat(0, 1, 0, 0, 200, 1'b1, 127, "relu_c");
        dir_beat(0, 3, 2, 0, -64, 1'b1, -2, "leaky_a");
        dir_beat(0, 3, 2, 0, -1, 1'b1, -1, "leaky_b");
        dir_beat(0, 3, 2, 0, 40, 1'b1, 10, "leaky_c");
        dir_beat(0, 2, 0, 6, 3, 1'b0, 3, "clip_a");
        dir_beat(0, 0, 0, 6, 9, 1'b0, 6, "clip_b");
        dir_beat(0, 0, 0, 6, -4, 1'b1, 0, "clip_c");
        dir_beat(0, 0, 0, 6, -4, 1'b1, -4, "next_pkt");
        dir_beat(NUM_CH - 1, 0, 0, 0, -300, 1'b1, -128, "bypass_neg");
        dir_beat(0, 0, 4, 0, 32767, 1'b1, 127, "sat_pos");
        dir_beat(0, 0, 15, 0, -32768, 1'b1, -1, "shift_max");
        @(negedge clk);
        check("idle_busy", bus.busy, 0);

        run_random(400, 100, 70, 1'b0);
        run_random(400, 50, 80, 1'b0);
        run_random(300, 15, 90, 1'b0);
        run_random(200, 60, 70, 1'b1);
        mid_reset();
        run_random(300, 70, 60, 1'b0);
        run_random(10, 100, 0, 1'b0);
        for (int l = 0; l < NUM_CH; l++)
            check($sformatf("drain_l%0d", l), q[l].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
